// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA command path.
package dma_pkg;

  localparam int DMA_ADDR_W  = 64;
  localparam int DMA_LEN_W   = 64;
  localparam int BOUNDARY_4K = 4096;

  localparam int CMDQ_FILL_LSB = 0;
  localparam int CMDQ_FILL_MSB = 7;
  localparam int CMDQ_FULL     = 8;
  localparam int CMDQ_EMPTY    = 9;
  localparam int CMDQ_OVF      = 10;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  length;
  } dma_cmd_t;

  typedef enum logic [1:0] {
    BG_IDLE      = 2'd0,
    BG_LOAD      = 2'd1,
    BG_ISSUE     = 2'd2,
    BG_WAIT_DONE = 2'd3
  } bg_state_e;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Command queue: synchronous FIFO of dma_cmd_t with fill count and flush.
module dma_cmd_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        wr_en_i,
  input  dma_cmd_t    wr_data_i,
  input  logic        rd_en_i,
  output dma_cmd_t    rd_data_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  dma_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = wr_en_i && !full_o;
  assign pop     = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/dma_cmd_burst_gen.sv
// Splits queued DMA commands into line bursts that respect MAX_BURST and 4KB pages.
// state     | meaning
// IDLE      | waiting for a queued command; pops the head when present
// LOAD      | converts length to lines, loads burst address registers
// ISSUE     | presents bursts to the data mover until the last one is taken
// WAIT_DONE | waiting for the data mover to finish writing the last burst
module dma_cmd_burst_gen
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int LEN_WIDTH      = 64,
  parameter int CMDQ_DEPTH     = 8,
  parameter int LINE_BYTES     = 64,
  parameter int MAX_BURST      = 4,
  parameter int BURSTCNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_cmd,
  input  logic [ADDR_WIDTH-1:0]     cmd_src_addr,
  input  logic [ADDR_WIDTH-1:0]     cmd_dst_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_xfer_length,
  input  logic                      sclr,
  input  logic                      clear_irq,
  output logic [63:0]               cmdq_status,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [ADDR_WIDTH-1:0]     req_src_addr,
  output logic [ADDR_WIDTH-1:0]     req_dst_addr,
  output logic [BURSTCNT_WIDTH-1:0] req_burstcount,
  output logic                      req_last,
  input  logic                      done,
  output logic                      busy,
  output logic                      irq,
  output logic [63:0]               burst_cnt
);

  localparam int LINE_SHIFT = $clog2(LINE_BYTES);
  localparam int QAW        = $clog2(CMDQ_DEPTH);

  bg_state_e             state_q, state_d;
  dma_cmd_t              cmd_q, push_cmd, head_cmd;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0]  rem_q, cmd_len;
  logic [63:0]           burst_cnt_q;
  logic                  irq_q, ovf_q;
  logic                  cmd_nonzero, pop, accept;
  logic                  q_full, q_empty;
  logic [QAW:0]          q_count;
  logic [12:0]           src_room, dst_room, bc_wide;

  assign cmd_nonzero = (cmd_xfer_length != '0);
  assign push_cmd    = '{src:    DMA_ADDR_W'(cmd_src_addr),
                         dst:    DMA_ADDR_W'(cmd_dst_addr),
                         length: DMA_LEN_W'(cmd_xfer_length)};

  dma_cmd_fifo #(.DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (sclr),
    .wr_en_i   (new_cmd && cmd_nonzero),
    .wr_data_i (push_cmd),
    .rd_en_i   (pop),
    .rd_data_o (head_cmd),
    .count_o   (q_count),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  // Burst size is the tightest of: burst cap, lines left, and room before either 4KB page ends.
  always_comb begin
    src_room = (13'(BOUNDARY_4K) - {1'b0, src_q[11:0]}) >> LINE_SHIFT;
    dst_room = (13'(BOUNDARY_4K) - {1'b0, dst_q[11:0]}) >> LINE_SHIFT;
    bc_wide  = 13'(MAX_BURST);
    if (rem_q < LEN_WIDTH'(bc_wide)) bc_wide = rem_q[12:0];
    if (src_room < bc_wide)          bc_wide = src_room;
    if (dst_room < bc_wide)          bc_wide = dst_room;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    req_valid = 1'b0;
    case (state_q)
      BG_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_d = BG_LOAD;
        end
      end
      BG_LOAD:      state_d = BG_ISSUE;
      BG_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready && req_last) state_d = BG_WAIT_DONE;
      end
      BG_WAIT_DONE: if (done) state_d = BG_IDLE;
      default:      state_d = BG_IDLE;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign cmd_len = LEN_WIDTH'(cmd_q.length);

  always_ff @(posedge clk) begin
    if (reset || sclr) begin
      state_q     <= BG_IDLE;
      cmd_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      burst_cnt_q <= '0;
      irq_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= head_cmd;
      if (state_q == BG_LOAD) begin
        src_q <= ADDR_WIDTH'(cmd_q.src);
        dst_q <= ADDR_WIDTH'(cmd_q.dst);
        rem_q <= (cmd_len >> LINE_SHIFT) + LEN_WIDTH'(|cmd_len[LINE_SHIFT-1:0]);
      end
      if (accept) begin
        src_q       <= src_q + (ADDR_WIDTH'(bc_wide) << LINE_SHIFT);
        dst_q       <= dst_q + (ADDR_WIDTH'(bc_wide) << LINE_SHIFT);
        rem_q       <= rem_q - LEN_WIDTH'(bc_wide);
        burst_cnt_q <= burst_cnt_q + 64'd1;
      end
      if (new_cmd && cmd_nonzero && q_full) ovf_q <= 1'b1;
      // done wins over a coincident clear so a completion is never lost
      if (state_q == BG_WAIT_DONE && done) irq_q <= 1'b1;
      else if (clear_irq)                  irq_q <= 1'b0;
    end
  end

  always_comb begin
    cmdq_status = '0;
    cmdq_status[CMDQ_FILL_MSB:CMDQ_FILL_LSB] = 8'(q_count);
    cmdq_status[CMDQ_FULL]  = q_full;
    cmdq_status[CMDQ_EMPTY] = q_empty;
    cmdq_status[CMDQ_OVF]   = ovf_q;
  end

  assign req_src_addr   = src_q;
  assign req_dst_addr   = dst_q;
  assign req_burstcount = BURSTCNT_WIDTH'(bc_wide);
  assign req_last       = (state_q == BG_ISSUE) && (LEN_WIDTH'(bc_wide) == rem_q);
  assign busy           = !q_empty || (state_q != BG_IDLE);
  assign irq            = irq_q;
  assign burst_cnt      = burst_cnt_q;

endmodule

// File: tb/tb_dma_cmd_burst_gen.sv
// Bench for dma_cmd_burst_gen: directed vector table, corner sequences, random scoreboard.
module tb_dma_cmd_burst_gen;

  logic        clk = 1'b0;
  logic        reset, new_cmd, sclr, clear_irq, req_ready, done;
  logic [63:0] cmd_src_addr, cmd_dst_addr, cmd_xfer_length;
  logic [63:0] cmdq_status, req_src_addr, req_dst_addr, burst_cnt;
  logic        req_valid, req_last, busy, irq;
  logic [2:0]  req_burstcount;

  always #5 clk = ~clk;

  dma_cmd_burst_gen dut (
    .clk             (clk),
    .reset           (reset),
    .new_cmd         (new_cmd),
    .cmd_src_addr    (cmd_src_addr),
    .cmd_dst_addr    (cmd_dst_addr),
    .cmd_xfer_length (cmd_xfer_length),
    .sclr            (sclr),
    .clear_irq       (clear_irq),
    .cmdq_status     (cmdq_status),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_src_addr    (req_src_addr),
    .req_dst_addr    (req_dst_addr),
    .req_burstcount  (req_burstcount),
    .req_last        (req_last),
    .done            (done),
    .busy            (busy),
    .irq             (irq),
    .burst_cnt       (burst_cnt)
  );

  typedef struct packed {
    logic [63:0] src, dst, len;
    logic [7:0]  nb;
    logic [63:0] f_src, f_dst;
    logic [7:0]  f_bc;
    logic [63:0] l_src, l_dst;
    logic [7:0]  l_bc;
  } vec_t;

  typedef struct packed {
    logic [63:0] src, dst;
    logic [2:0]  bc;
    logic        last;
  } burst_t;

  vec_t   vecs [6];
  burst_t exp_q [$];
  int     n_vec = 0;
  int     n_fail = 0;
  int     total_exp = 0;
  int     burst_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: split a command into bursts straight from the burst sizing rules.
  task automatic gen_bursts(input logic [63:0] s, input logic [63:0] d, input logic [63:0] len);
    logic [63:0] rem, n, sroom, droom;
    rem = len / 64 + ((len % 64 != 0) ? 64'd1 : 64'd0);
    while (rem != 0) begin
      n = 4;
      if (rem < n) n = rem;
      sroom = (64'd4096 - (s % 64'd4096)) / 64;
      droom = (64'd4096 - (d % 64'd4096)) / 64;
      if (sroom < n) n = sroom;
      if (droom < n) n = droom;
      exp_q.push_back('{src: s, dst: d, bc: n[2:0], last: (n == rem)});
      total_exp++;
      s   = s + n * 64;
      d   = d + n * 64;
      rem = rem - n;
    end
  endtask

  task automatic issue_cmd(input logic [63:0] s, input logic [63:0] d, input logic [63:0] len);
    cmd_src_addr = s;
    cmd_dst_addr = d;
    cmd_xfer_length = len;
    new_cmd = 1'b1;
    tick();
    new_cmd = 1'b0;
  endtask

  // One-line command with req_ready=1; returns once the burst is taken (FSM waiting for done).
  task automatic single_burst_cmd(input logic [63:0] s);
    int g;
    issue_cmd(s, 64'h0, 64'd64);
    g = 0;
    while (!req_valid && g < 10) begin
      tick();
      g++;
    end
    chk("sb_valid", 64'(req_valid), 64'd1);
    tick();
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = {$urandom, $urandom} & ~64'h3F;
    case ($urandom_range(0, 3))
      0: a = (a & ~64'hFFF) | (64'hFC0 - 64'(64 * $urandom_range(0, 4)));
      1: a = 64'hFFFF_FFFF_FFFF_FFC0 - 64'(64 * $urandom_range(0, 3));
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fs, fd, ls, ld, hold_src, s, d, len;
    logic [7:0]  fb, lb;
    logic [2:0]  hold_bc;
    int          nb, guard, cyc, outstanding, done_wait;
    bit          got_last, exp_irq, prev_done, prev_clr, issuing;
    burst_t      e;

    vecs[0] = '{src:64'h1000, dst:64'h0, len:64'd256, nb:8'd1,
                f_src:64'h1000, f_dst:64'h0, f_bc:8'd4, l_src:64'h1000, l_dst:64'h0, l_bc:8'd4};
    vecs[1] = '{src:64'hFC0, dst:64'h2000, len:64'd192, nb:8'd2,
                f_src:64'hFC0, f_dst:64'h2000, f_bc:8'd1, l_src:64'h1000, l_dst:64'h2040, l_bc:8'd2};
    vecs[2] = '{src:64'h0, dst:64'h0, len:64'd100, nb:8'd1,
                f_src:64'h0, f_dst:64'h0, f_bc:8'd2, l_src:64'h0, l_dst:64'h0, l_bc:8'd2};
    vecs[3] = '{src:64'h0, dst:64'hF80, len:64'd640, nb:8'd3,
                f_src:64'h0, f_dst:64'hF80, f_bc:8'd2, l_src:64'h180, l_dst:64'h1100, l_bc:8'd4};
    vecs[4] = '{src:64'hFFFF_FFFF_FFFF_FF80, dst:64'h40, len:64'd200, nb:8'd2,
                f_src:64'hFFFF_FFFF_FFFF_FF80, f_dst:64'h40, f_bc:8'd2, l_src:64'h0, l_dst:64'hC0, l_bc:8'd2};
    vecs[5] = '{src:64'h40, dst:64'h80, len:64'd1, nb:8'd1,
                f_src:64'h40, f_dst:64'h80, f_bc:8'd1, l_src:64'h40, l_dst:64'h80, l_bc:8'd1};

    reset = 1'b1; new_cmd = 1'b0; sclr = 1'b0; clear_irq = 1'b0; done = 1'b0; req_ready = 1'b1;
    cmd_src_addr = '0; cmd_dst_addr = '0; cmd_xfer_length = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_req_last", 64'(req_last), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_burst_cnt", burst_cnt, 64'd0);
    chk("rst_cmdq_status", cmdq_status, 64'h200);

    for (int i = 0; i < 6; i++) begin
      issue_cmd(vecs[i].src, vecs[i].dst, vecs[i].len);
      nb = 0; got_last = 0; guard = 0;
      fs = '0; fd = '0; fb = '0; ls = '0; ld = '0; lb = '0;
      while (!got_last && guard < 40) begin
        if (req_valid) begin
          if (nb == 0) begin
            fs = req_src_addr; fd = req_dst_addr; fb = 8'(req_burstcount);
          end
          ls = req_src_addr; ld = req_dst_addr; lb = 8'(req_burstcount);
          nb++;
          if (req_last) got_last = 1;
        end
        tick();
        guard++;
      end
      chk($sformatf("vec%0d_got_last", i), 64'(got_last), 64'd1);
      chk($sformatf("vec%0d_nbursts", i), 64'(nb), 64'(vecs[i].nb));
      chk($sformatf("vec%0d_first_src", i), fs, vecs[i].f_src);
      chk($sformatf("vec%0d_first_dst", i), fd, vecs[i].f_dst);
      chk($sformatf("vec%0d_first_bc", i), 64'(fb), 64'(vecs[i].f_bc));
      chk($sformatf("vec%0d_last_src", i), ls, vecs[i].l_src);
      chk($sformatf("vec%0d_last_dst", i), ld, vecs[i].l_dst);
      chk($sformatf("vec%0d_last_bc", i), 64'(lb), 64'(vecs[i].l_bc));
      chk($sformatf("vec%0d_wait_valid", i), 64'(req_valid), 64'd0);
      done = 1'b1; tick(); done = 1'b0;
      chk($sformatf("vec%0d_irq", i), 64'(irq), 64'd1);
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      burst_total += int'(vecs[i].nb);
      chk($sformatf("vec%0d_burst_cnt", i), burst_cnt, 64'(burst_total));
      clear_irq = 1'b1; tick(); clear_irq = 1'b0;
      chk($sformatf("vec%0d_irq_clr", i), 64'(irq), 64'd0);
    end

    // Latency N -> N+3 and payload hold while the data mover stalls.
    req_ready = 1'b0;
    issue_cmd(64'h2000, 64'h3000, 64'd128);
    chk("lat_fill_n1", cmdq_status, 64'h001);
    tick();
    chk("lat_valid_n2", 64'(req_valid), 64'd0);
    chk("lat_fill_n2", cmdq_status, 64'h200);
    tick();
    chk("lat_valid_n3", 64'(req_valid), 64'd1);
    hold_src = req_src_addr; hold_bc = req_burstcount;
    chk("lat_src", hold_src, 64'h2000);
    chk("lat_bc", 64'(hold_bc), 64'd2);
    repeat (3) tick();
    chk("hold_valid", 64'(req_valid), 64'd1);
    chk("hold_src", req_src_addr, 64'h2000);
    chk("hold_dst", req_dst_addr, 64'h3000);
    chk("hold_bc_last", {req_burstcount, req_last}, {3'd2, 1'b1});
    req_ready = 1'b1; tick();
    chk("hold_accepted", 64'(req_valid), 64'd0);
    burst_total++;
    chk("hold_burst_cnt", burst_cnt, 64'(burst_total));
    done = 1'b1; tick(); done = 1'b0;
    clear_irq = 1'b1; tick(); clear_irq = 1'b0;

    // Zero-length command is ignored.
    issue_cmd(64'h4000, 64'h5000, 64'd0);
    chk("len0_status", cmdq_status, 64'h200);
    chk("len0_busy", 64'(busy), 64'd0);
    tick();
    chk("len0_valid", 64'(req_valid), 64'd0);

    // irq stickiness, done/clear collision, done outside WAIT_DONE.
    single_burst_cmd(64'h6000);
    done = 1'b1; tick(); done = 1'b0;
    chk("irq_set", 64'(irq), 64'd1);
    single_burst_cmd(64'h7000);
    done = 1'b1; clear_irq = 1'b1; tick(); done = 1'b0; clear_irq = 1'b0;
    chk("irq_done_and_clear", 64'(irq), 64'd1);
    chk("irq_seq_busy", 64'(busy), 64'd0);
    clear_irq = 1'b1; tick(); clear_irq = 1'b0;
    chk("irq_lone_clear", 64'(irq), 64'd0);
    done = 1'b1; tick(); done = 1'b0;
    chk("done_ignored_idle", 64'(irq), 64'd0);
    burst_total += 2;
    chk("irq_seq_burst_cnt", burst_cnt, 64'(burst_total));

    // Overflow with a stalled data mover, then soft clear mid-request.
    req_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cmd_src_addr = 64'h10000 + 64'(k * 64);
      cmd_dst_addr = 64'h20000;
      cmd_xfer_length = 64'd64;
      new_cmd = 1'b1;
      tick();
    end
    new_cmd = 1'b0;
    chk("ovf_status", cmdq_status, 64'h508);
    chk("ovf_valid", 64'(req_valid), 64'd1);
    chk("ovf_head_src", req_src_addr, 64'h10000);
    chk("ovf_busy", 64'(busy), 64'd1);
    sclr = 1'b1; tick(); sclr = 1'b0;
    chk("sclr_valid", 64'(req_valid), 64'd0);
    chk("sclr_status", cmdq_status, 64'h200);
    chk("sclr_burst_cnt", burst_cnt, 64'd0);
    chk("sclr_busy", 64'(busy), 64'd0);
    chk("sclr_irq", 64'(irq), 64'd0);

    // Random traffic against the burst scoreboard.
    outstanding = 0; done_wait = 0; exp_irq = 0; prev_done = 0; prev_clr = 0;
    total_exp = 0; cyc = 0;
    exp_q.delete();
    while (cyc < 8000) begin
      @(posedge clk); #1;
      if (prev_done) exp_irq = 1;
      else if (prev_clr) exp_irq = 0;
      new_cmd = 1'b0; done = 1'b0; clear_irq = 1'b0;
      issuing = (cyc < 3000);
      if (!issuing && outstanding == 0 && exp_q.size() == 0) break;
      req_ready = ($urandom_range(0, 3) != 0);
      if (issuing && outstanding < 6 && $urandom_range(0, 3) == 0) begin
        s = rnd_addr();
        d = rnd_addr();
        len = ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(1, 700));
        cmd_src_addr = s; cmd_dst_addr = d; cmd_xfer_length = len;
        new_cmd = 1'b1;
        if (len != 0) begin
          gen_bursts(s, d, len);
          outstanding++;
        end
      end
      if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) begin
          done = 1'b1;
          outstanding--;
        end
      end
      if ($urandom_range(0, 7) == 0) clear_irq = 1'b1;
      prev_done = done; prev_clr = clear_irq;
      @(negedge clk);
      chk("rnd_irq", 64'(irq), 64'(exp_irq));
      if (req_valid && req_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_burst", 64'd1, 64'(exp_q.size()));
        end else begin
          e = exp_q.pop_front();
          chk("rnd_src", req_src_addr, e.src);
          chk("rnd_dst", req_dst_addr, e.dst);
          chk("rnd_bc_last", 64'({req_burstcount, req_last}), 64'({e.bc, e.last}));
          if (e.last) done_wait = $urandom_range(1, 4);
        end
      end
      cyc++;
    end
    new_cmd = 1'b0; done = 1'b0; clear_irq = 1'b0;
    tick();
    chk("rnd_drained", 64'(exp_q.size() + outstanding), 64'd0);
    chk("rnd_burst_cnt", burst_cnt, 64'(total_exp));
    chk("rnd_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
